cache_sa_wb: RTL and testbench
==============================

Name: cache_sa_wb

Overview:
- Parametrised set-associative, write-back, write-allocate cache; next generation of the direct single-cycle cache.
- Sits between a CPU load/store port (valid/ready request, registered response) and a word-wide backing-memory port (req/ack handshake).
- Adds configurable sets and ways, dirty-line write-back, round-robin replacement and hit/miss counters.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word and line width (one word per line).
- NUM_SETS, 16, number of sets; power of 2, ≥2.
- WAYS, 2, associativity; power of 2, 1..8.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  block accepts a request when req_valid & req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  response was a hit.
- resp_rdata  out  DATA_W  load data, or stored word for a store.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = write-back, 0 = refill read.
- mem_addr  out  ADDR_W  word-aligned line address.
- mem_wdata  out  DATA_W  write-back data.
- mem_ack  in  1  transfer completes at the edge where mem_req & mem_ack.
- mem_rdata  in  DATA_W  refill data, valid with mem_ack.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Address split: index = addr[IDX_W+1:2] with IDX_W = log2(NUM_SETS); tag = the remaining upper bits.
- Reset (synchronous, rst=1 at an edge):
  - All valid and dirty bits cleared; victim pointers cleared to 0; state IDLE.
  - req_ready=1; resp_valid=0; resp_hit=0; resp_rdata=0.
  - mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; counters=0.
  - Reset mid-operation aborts the transaction: mem_req drops after that edge; dirty data is discarded; no response is issued.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND. req_ready=1 only in IDLE.
- IDLE: on accept, register addr/write/wdata and go to LOOKUP.
- LOOKUP (one cycle): compare tags of all valid ways in the set.
  - Hit: a load returns the way's data; a store writes the word and sets dirty.
  - Hit response: resp_valid=1, resp_hit=1 in the next cycle; go to IDLE; hit_count+1.
  - Hit latency: resp_valid is high in the cycle after the 2nd edge following acceptance. Throughput is one request per 2 cycles.
  - Miss: miss_count+1. Victim = lowest-numbered invalid way, else the set's round-robin pointer.
  - Miss with a valid, dirty victim: go to WRITEBACK. Otherwise go to REFILL.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, mem_wdata=victim data.
  - All four outputs are held stable until the ack edge; then go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={req tag, index, 2'b00}.
  - On ack: install mem_rdata into the victim way, set valid, update tag.
  - A store merges req_wdata and sets dirty=1; a load sets dirty=0.
  - Pointer ← (victim+1) mod WAYS. Go to RESPOND.
- RESPOND: resp_valid=1, resp_hit=0, resp_rdata = installed word; go to IDLE.
- mem_req deasserts the cycle after ack. mem_ack while mem_req=0 is ignored.
- An ack at the same edge mem_req first rises is legal.
- req_valid while req_ready=0 is ignored; the CPU holds the request.
- Counters saturate at all-ones and do not wrap.
- WAYS=1 degenerates to direct-mapped; the pointer stays 0.

Test Plan:
- Reset, load 0x1000, memory acks with 0x11111111 → one refill read at mem_addr 0x1000; resp_hit=0, rdata 0x11111111. Repeat load → resp_hit=1, rdata 0x11111111, no mem_req, response 2 edges after accept.
- Store 0x1000 ← 0xDEADBEEF → resp_hit=1, no mem traffic. Load 0x1000 → resp_hit=1, rdata 0xDEADBEEF.
- Load 0x2000 (fills way1), then load 0x3000 (all set 0, WAYS=2):
  - Write-back mem_we=1, mem_addr 0x1000, mem_wdata 0xDEADBEEF.
  - Then refill at 0x3000; resp_hit=0.
  - Load 0x1000 misses; refill only, no write-back, since the victim is clean.
- Hold mem_ack low 5 cycles during refill → mem_req, mem_addr stable; req_ready=0; a toggling req_valid has no effect.
- Assert rst for one edge during REFILL → next cycle mem_req=0, resp_valid=0, req_ready=1, counters 0. Reload 0x3000 → miss.
- With CNT_W=2, perform 5 hits → hit_count saturates at 3.

Source files
------------

// File: rtl/cache_sa_wb.sv
// Set-associative, write-back, write-allocate cache with one word per line.
// A CPU request is captured in IDLE and looked up in the following cycle.
// A miss optionally writes back a dirty victim, then refills from memory,
// and finally responds. Hit and miss counters saturate at all-ones.
module cache_sa_wb #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_SETS = 16,
    parameter int WAYS     = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        RESPOND
    } state_t;

    state_t state, state_nxt;

    // Request captured at acceptance (word address, direction, store data)
    logic [ADDR_W-3:0] line_p0;
    logic              write_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [WAY_W-1:0]  victim_p0;

    // Line storage and per-set replacement state
    logic [WAYS-1:0]   valid_r [NUM_SETS];
    logic [WAYS-1:0]   dirty_r [NUM_SETS];
    logic [WAY_W-1:0]  ptr_r   [NUM_SETS];
    logic [TAG_W-1:0]  tag_r   [NUM_SETS][WAYS];
    logic [DATA_W-1:0] data_r  [NUM_SETS][WAYS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              inv_found;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  wi;
    logic [WAY_W-1:0]  vic_way;
    logic              vic_dirty;
    logic [DATA_W-1:0] fill_word;

    // Byte-offset bits never select anything in a word-wide line.
    logic unused_bits;
    assign unused_bits = ^req_addr[1:0];

    assign idx       = line_p0[IDX_W-1:0];
    assign tag       = line_p0[ADDR_W-3:IDX_W];
    assign vic_way   = inv_found ? inv_way : ptr_r[idx];
    assign vic_dirty = valid_r[idx][vic_way] & dirty_r[idx][vic_way];
    assign fill_word = write_p0 ? wdata_p0 : mem_rdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Tag compare across the set; also find the lowest-numbered invalid way
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        wi        = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            wi = WAY_W'(w);
            if (valid_r[idx][wi] && (tag_r[idx][wi] == tag)) begin
                hit     = 1'b1;
                hit_way = wi;
            end
            if (!valid_r[idx][wi]) begin
                inv_found = 1'b1;
                inv_way   = wi;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and memory-port outputs
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (hit)            state_nxt = IDLE;
                else if (vic_dirty) state_nxt = WRITEBACK;
                else                state_nxt = REFILL;
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_r[idx][victim_p0], idx, 2'b00};
                mem_wdata = data_r[idx][victim_p0];
                if (mem_ack) state_nxt = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {line_p0, 2'b00};
                if (mem_ack) state_nxt = RESPOND;
            end
            RESPOND: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: valid/dirty bits, replacement pointers, response, counters
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r    <= '{default: '0};
            dirty_r    <= '{default: '0};
            ptr_r      <= '{default: '0};
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_rdata <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            case (state)
                LOOKUP: begin
                    if (hit) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b1;
                        hit_count  <= sat_inc(hit_count);
                        if (write_p0) begin
                            dirty_r[idx][hit_way] <= 1'b1;
                            resp_rdata            <= wdata_p0;
                        end else begin
                            resp_rdata <= data_r[idx][hit_way];
                        end
                    end else begin
                        miss_count <= sat_inc(miss_count);
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        valid_r[idx][victim_p0] <= 1'b1;
                        dirty_r[idx][victim_p0] <= write_p0;
                        ptr_r[idx]              <= (WAYS == 1) ? '0 : victim_p0 + 1'b1;
                        resp_valid              <= 1'b1;
                        resp_rdata              <= fill_word;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath: captured request, victim choice, tag and data arrays
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (req_valid) begin
                    line_p0  <= req_addr[ADDR_W-1:2];
                    write_p0 <= req_write;
                    wdata_p0 <= req_wdata;
                end
            end
            LOOKUP: begin
                if (hit && write_p0) data_r[idx][hit_way] <= wdata_p0;
                if (!hit)            victim_p0 <= vic_way;
            end
            REFILL: begin
                if (mem_ack) begin
                    tag_r[idx][victim_p0]  <= tag;
                    data_r[idx][victim_p0] <= fill_word;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_sa_wb.sv
// Directed bench for cache_sa_wb (2-way, 16 sets, 2-bit counters).
// Expected responses and memory transfers are queued as stimulus is issued
// and checked when the DUT produces them.
module tb_cache_sa_wb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_hit;
    logic [DW-1:0] resp_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] hit_count, miss_count;

    always #5 clk = ~clk;

    cache_sa_wb #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SETS(16), .WAYS(2), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mop_t;

    int          tests = 0;
    int          fails = 0;
    int          ack_wait = 0;
    logic        sb_hit[$];
    logic [31:0] sb_data[$];
    mop_t        exp_mem[$];
    logic [31:0] mem [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_op(input logic we, input logic [31:0] a, input logic [31:0] d);
        mop_t m;
        m.we = we; m.addr = a; m.wdata = d;
        exp_mem.push_back(m);
    endtask

    // Response scoreboard
    initial begin
        logic        eh;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (sb_hit.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    eh = sb_hit.pop_front();
                    ed = sb_data.pop_front();
                    chk("resp_hit", 32'(resp_hit), 32'(eh));
                    chk("resp_rdata", resp_rdata, ed);
                end
            end
        end
    end

    // Memory responder: acks after ack_wait cycles of mem_req, checks each transfer
    initial begin
        int   wcnt;
        mop_t m;
        wcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                if (wcnt >= ack_wait) begin
                    wcnt    = 0;
                    mem_ack = 1'b1;
                    if (exp_mem.size() == 0) begin
                        chk("unexpected_mem", 32'(mem_req), 32'd0);
                    end else begin
                        m = exp_mem.pop_front();
                        chk("mem_we", 32'(mem_we), 32'(m.we));
                        chk("mem_addr", mem_addr, m.addr);
                        if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                    end
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, output bit ok);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic finish_req(input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (resp_valid !== 1'b1 && lat < 300);
        chk("resp_timeout", 32'(resp_valid), 32'd1);
        if (exp_lat > 0) chk("resp_latency", 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
        chk("mem_ops_done", 32'(exp_mem.size()), 32'd0);
        chk("sb_drained", 32'(sb_hit.size()), 32'd0);
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic eh, input logic [31:0] ed, input int lat);
        bit ok;
        sb_hit.push_back(eh);
        sb_data.push_back(ed);
        send(w, a, d, ok);
        if (ok) finish_req(lat);
    endtask

    task automatic wait_mem_req();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) break;
        end
        chk("mem_req_rise", 32'(mem_req), 32'd1);
    endtask

    // Directed sequence
    initial begin
        bit ok;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        mem[32'h1000] = 32'h11111111;
        mem[32'h2000] = 32'h22222222;
        mem[32'h3000] = 32'h33333333;
        mem[32'h4000] = 32'h44444444;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_hit", 32'(resp_hit), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_hit_count", 32'(hit_count), 32'd0);
        chk("rst_miss_count", 32'(miss_count), 32'd0);
        rst = 1'b0;

        // Cold miss, then hits (load, store, load)
        exp_op(1'b0, 32'h1000, 32'h0);
        do_req(1'b0, 32'h1000, 32'h0, 1'b0, 32'h11111111, 3);
        do_req(1'b0, 32'h1000, 32'h0, 1'b1, 32'h11111111, 2);
        do_req(1'b1, 32'h1000, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 2);
        do_req(1'b0, 32'h1000, 32'h0, 1'b1, 32'hDEADBEEF, 2);
        chk("hit_count_3", 32'(hit_count), 32'd3);
        chk("miss_count_1", 32'(miss_count), 32'd1);

        // Fill way1, then evict dirty way0 with write-back, then clean eviction
        exp_op(1'b0, 32'h2000, 32'h0);
        do_req(1'b0, 32'h2000, 32'h0, 1'b0, 32'h22222222, 0);
        exp_op(1'b1, 32'h1000, 32'hDEADBEEF);
        exp_op(1'b0, 32'h3000, 32'h0);
        do_req(1'b0, 32'h3000, 32'h0, 1'b0, 32'h33333333, 0);
        exp_op(1'b0, 32'h1000, 32'h0);
        do_req(1'b0, 32'h1000, 32'h0, 1'b0, 32'hDEADBEEF, 3);
        chk("miss_count_sat", 32'(miss_count), 32'd3);

        // Two more hits: five in total, counter saturates
        do_req(1'b0, 32'h3000, 32'h0, 1'b1, 32'h33333333, 2);
        do_req(1'b0, 32'h1000, 32'h0, 1'b1, 32'hDEADBEEF, 2);
        chk("hit_count_sat", 32'(hit_count), 32'd3);

        // Slow memory: outputs hold, CPU side stalls, stray req_valid ignored
        ack_wait = 5;
        exp_op(1'b0, 32'h2000, 32'h0);
        sb_hit.push_back(1'b0);
        sb_data.push_back(32'h22222222);
        send(1'b0, 32'h2000, 32'h0, ok);
        wait_mem_req();
        for (int k = 0; k < 5; k++) begin
            chk("hold_mem_req", 32'(mem_req), 32'd1);
            chk("hold_mem_addr", mem_addr, 32'h2000);
            chk("hold_mem_we", 32'(mem_we), 32'd0);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            req_valid = ~req_valid; req_write = 1'b1; req_addr = 32'h5000; req_wdata = 32'hBAD0BAD0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        ack_wait  = 0;
        finish_req(0);

        // Reset during refill aborts the transaction
        ack_wait = 1000;
        send(1'b0, 32'h4000, 32'h0, ok);
        wait_mem_req();
        chk("abort_mem_addr", mem_addr, 32'h4000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_hit_count", 32'(hit_count), 32'd0);
        chk("abort_miss_count", 32'(miss_count), 32'd0);
        chk("abort_mem_addr0", mem_addr, 32'd0);
        ack_wait = 0;
        repeat (3) @(negedge clk);

        // Cache contents were invalidated
        exp_op(1'b0, 32'h3000, 32'h0);
        do_req(1'b0, 32'h3000, 32'h0, 1'b0, 32'h33333333, 3);
        chk("post_rst_miss_count", 32'(miss_count), 32'd1);
        chk("post_rst_hit_count", 32'(hit_count), 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
